// File: rtl/tx_ofdm_symbol_scheduler.sv
// Buffers mapped subcarriers and releases each OFDM symbol as one contiguous
// SYM_LEN-beat burst, with burst starts spaced one CP-extended symbol period apart.
module tx_ofdm_symbol_scheduler #(
    parameter int SYM_LEN    = 52,
    parameter int SYM_PERIOD = 160,
    parameter int BUF_DEPTH  = 128,
    parameter int DW         = 32
) (
    input  logic          clk_Modulation,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   n_ofdm_syms,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    output logic          tx_freqd_to_timed_valid,
    output logic [DW-1:0] tx_freqd_to_timed_re,
    output logic [DW-1:0] tx_freqd_to_timed_im,
    input  logic          tx_add_cyclic_prefix_end,
    output logic          busy,
    output logic          done,
    output logic [15:0]   sym_cnt
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int FW = AW + 1;
    localparam int BW = $clog2(SYM_LEN);
    localparam int GW = $clog2(SYM_PERIOD);
    localparam logic [GW-1:0] GAP_INIT = GW'(SYM_PERIOD - SYM_LEN - 1);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, BURST, GAP, DRAIN} state_t;

    state_t          r_state;
    logic [2*DW-1:0] r_mem [BUF_DEPTH];
    logic [2*DW-1:0] r_rd_data;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [FW-1:0]   r_fill;
    logic [23:0]     r_accepted;
    logic [23:0]     r_quota;
    logic [15:0]     r_n_lat;
    logic [15:0]     r_sym_cnt;
    logic [BW-1:0]   r_beat;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic w_accept;
    logic w_read;
    logic w_sym_ready;

    assign s_ready     = (r_state != IDLE) && (r_fill < FW'(BUF_DEPTH)) && (r_accepted < r_quota);
    assign w_accept    = s_valid && s_ready;
    assign w_read      = (r_state == BURST);
    assign w_sym_ready = (r_fill >= FW'(SYM_LEN));

    // Payload gated by the registered valid, so reset clears it without waiting for an edge.
    assign tx_freqd_to_timed_valid = r_valid;
    assign tx_freqd_to_timed_re    = r_valid ? r_rd_data[DW-1:0]    : '0;
    assign tx_freqd_to_timed_im    = r_valid ? r_rd_data[2*DW-1:DW] : '0;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sym_cnt = r_sym_cnt;

    always_ff @(posedge clk_Modulation) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {s_im, s_re};
        end
        r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk_Modulation or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_accepted <= '0;
            r_quota    <= '0;
            r_n_lat    <= '0;
            r_sym_cnt  <= '0;
            r_beat     <= '0;
            r_gap_cnt  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_accepted <= '0;
            r_sym_cnt  <= '0;
            r_beat     <= '0;
            r_gap_cnt  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_accepted <= r_accepted + 24'd1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fill <= r_fill + FW'(w_accept) - FW'(w_read);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (n_ofdm_syms == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_n_lat    <= n_ofdm_syms;
                            r_quota    <= 24'(n_ofdm_syms) * 24'(SYM_LEN);
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_fill     <= '0;
                            r_accepted <= '0;
                            r_sym_cnt  <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (w_sym_ready) begin
                        r_beat  <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    r_valid <= 1'b1;
                    if (r_beat == BW'(SYM_LEN - 1)) begin
                        r_sym_cnt <= r_sym_cnt + 16'd1;
                        if (r_sym_cnt + 16'd1 == r_n_lat) begin
                            r_state <= DRAIN;
                        end else begin
                            r_gap_cnt <= GAP_INIT;
                            r_state   <= GAP;
                        end
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                GAP: begin
                    // Launching straight from GAP keeps back-to-back starts exactly SYM_PERIOD apart.
                    if (r_gap_cnt == '0) begin
                        if (w_sym_ready) begin
                            r_beat  <= '0;
                            r_state <= BURST;
                        end else begin
                            r_state <= WAIT_DATA;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (tx_add_cyclic_prefix_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_no_underrun: assert property (@(posedge clk_Modulation) disable iff (!reset_n)
        (r_state == BURST) |-> (r_fill != '0));

endmodule

// File: tb/tb_tx_ofdm_symbol_scheduler.sv
// Directed bench for tx_ofdm_symbol_scheduler: frames checked against a sample-index
// scoreboard and a burst-start timing model, plus edge inputs, abort and async reset.
`timescale 1ns/1ps
module tb_tx_ofdm_symbol_scheduler;
    localparam int DW         = 32;
    localparam int SYM_LEN    = 52;
    localparam int SYM_PERIOD = 160;
    localparam int BUF_DEPTH  = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   n_syms = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_re = '0;
    logic [DW-1:0] s_im = '0;
    logic          cp_end = 1'b0;
    logic          s_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_re;
    logic [DW-1:0] tx_im;
    logic          busy;
    logic          done;
    logic [15:0]   sym_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    tx_ofdm_symbol_scheduler #(
        .SYM_LEN(SYM_LEN), .SYM_PERIOD(SYM_PERIOD), .BUF_DEPTH(BUF_DEPTH), .DW(DW)
    ) dut (
        .clk_Modulation          (clk),
        .reset_n                 (rst_n),
        .start                   (start),
        .abort                   (abort),
        .n_ofdm_syms             (n_syms),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready),
        .s_re                    (s_re),
        .s_im                    (s_im),
        .tx_freqd_to_timed_valid (tx_valid),
        .tx_freqd_to_timed_re    (tx_re),
        .tx_freqd_to_timed_im    (tx_im),
        .tx_add_cyclic_prefix_end(cp_end),
        .busy                    (busy),
        .done                    (done),
        .sym_cnt                 (sym_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    // One frame: sample k carries re=k, im=-k; every beat, burst start and the
    // s_ready rule are checked against the model. abort_burst < 0 means no abort.
    task automatic run_frame(input int n, input int interval, input int cp_delay,
                             input bit dup_start, input bit cp_in_gap,
                             input int abort_burst, output bit full_seen);
        int acc_cyc[$];
        int acc_cnt = 0, beats = 0, blen = 0, bursts = 0;
        int bstart = 0, prev_start = 0, exp_start = 0, fill_m = 0, idx = 0;
        int ready_err = 0, busy_err = 0, data_err = 0, done_cnt = 0;
        int done_cyc = -1, cp_cyc = -2, cp_wait = -1, steps = 0, tail = -1, gap_ctr = 0;
        int budget;
        bit acc_pend = 0, in_burst = 0, active = 1;
        full_seen = 0;
        budget = n * SYM_PERIOD + n * SYM_LEN * interval + 600;
        @(negedge clk);
        start  = 1'b1;
        n_syms = n[15:0];
        while (steps < budget && tail != 0) begin
            @(negedge clk);
            steps++;
            start  = 1'b0;
            cp_end = 1'b0;
            n_syms = n[15:0];
            if (abort) begin
                abort = 1'b0;
                check_eq("abort_valid", tx_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_sym_cnt", sym_cnt, 0);
                check_eq("abort_ready", s_ready, 0);
                active = 0;
                in_burst = 0;
                tail = 10;
            end
            if (acc_pend) begin
                acc_cyc.push_back(cyc);
                acc_cnt++;
            end
            if (tx_valid) begin
                if (!in_burst) begin
                    in_burst = 1;
                    blen = 0;
                    bstart = cyc;
                    idx = (bursts + 1) * SYM_LEN - 1;
                    exp_start = (acc_cyc.size() > idx) ? acc_cyc[idx] + 2 : -1;
                    if (bursts > 0 && prev_start + SYM_PERIOD > exp_start)
                        exp_start = prev_start + SYM_PERIOD;
                    check_eq($sformatf("burst%0d_start", bursts), bstart, exp_start);
                end
                if (tx_re !== DW'(beats) || tx_im !== -DW'(beats)) data_err++;
                beats++;
                blen++;
                if (bursts == abort_burst && blen == 21) abort = 1'b1;
            end else if (in_burst) begin
                in_burst = 0;
                prev_start = bstart;
                check_eq($sformatf("burst%0d_len", bursts), blen, SYM_LEN);
                bursts++;
                check_eq($sformatf("burst%0d_sym_cnt", bursts - 1), sym_cnt, bursts);
                $display("burst n=%0d idx=%0d start=%0d len=%0d sym_cnt=%0d",
                         n, bursts - 1, bstart, blen, sym_cnt);
                if (bursts == 1 && dup_start) begin
                    start  = 1'b1;
                    n_syms = 16'd1;
                end
                if (bursts == 1 && cp_in_gap) cp_end = 1'b1;
                if (bursts == n) cp_wait = cp_delay;
            end
            if (cp_wait == 0) begin
                cp_end = 1'b1;
                cp_cyc = cyc + 1;
                cp_wait = -1;
            end else if (cp_wait > 0) begin
                cp_wait--;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 0);
                active = 0;
                tail = 3;
            end
            if (tail > 0) tail--;
            if (active) begin
                fill_m = acc_cnt - beats;
                if (s_ready !== ((fill_m < BUF_DEPTH) && (acc_cnt < n * SYM_LEN))) ready_err++;
                if (busy !== 1'b1) busy_err++;
                if (fill_m == BUF_DEPTH) full_seen = 1;
            end
            if (gap_ctr > 0) begin
                gap_ctr--;
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
            end
            s_re = DW'(acc_cnt);
            s_im = -DW'(acc_cnt);
            acc_pend = s_valid && s_ready;
            if (acc_pend) gap_ctr = interval - 1;
        end
        s_valid = 1'b0;
        cp_end  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        check_eq("data_order", data_err, 0);
        check_eq("ready_rule", ready_err, 0);
        check_eq("busy_hold", busy_err, 0);
        if (abort_burst >= 0) begin
            check_eq("abort_no_done", done_cnt, 0);
            check_eq("abort_bursts", bursts, abort_burst);
        end else begin
            check_eq("bursts", bursts, n);
            check_eq("accepted", acc_cnt, n * SYM_LEN);
            check_eq("done_count", done_cnt, 1);
            check_eq("done_cycle", done_cyc, cp_cyc);
            check_eq("sym_cnt_end", sym_cnt, n);
            check_eq("busy_end", busy, 0);
        end
        $display("frame n=%0d interval=%0d bursts=%0d accepted=%0d done=%0d",
                 n, interval, bursts, acc_cnt, done_cnt);
    endtask

    initial begin
        bit full;
        int seen;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {tx_valid, busy, done, s_ready, sym_cnt}, 0);
        check_eq("reset_data", {tx_re, tx_im}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_ctrl", {tx_valid, busy, done, s_ready, sym_cnt}, 0);

        run_frame(1, 1, 5, 0, 0, -1, full);
        run_frame(4, 1, 3, 1, 0, -1, full);
        run_frame(2, 5, 4, 0, 1, -1, full);
        run_frame(5, 1, 2, 0, 0, -1, full);
        check_eq("buffer_full_seen", full, 1);

        @(negedge clk);
        start = 1'b1;
        n_syms = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check_eq("n0_done", done, 1);
        check_eq("n0_busy", busy, 0);
        @(negedge clk);
        check_eq("n0_done_one_cycle", done, 0);
        check_eq("n0_no_valid", {tx_valid, s_ready}, 0);
        $display("n=0 start handled");

        run_frame(3, 1, 2, 0, 0, 1, full);
        run_frame(1, 1, 2, 0, 0, -1, full);

        @(negedge clk);
        start = 1'b1;
        n_syms = 16'd2;
        @(negedge clk);
        start = 1'b0;
        s_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 300 && seen < 10; i++) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        check_eq("rst_reached_burst", seen, 10);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ctrl", {tx_valid, busy, done, s_ready, sym_cnt}, 0);
        check_eq("async_rst_data", {tx_re, tx_im}, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset mid-burst handled");
        run_frame(1, 1, 1, 0, 0, -1, full);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
